// File: rtl/sha256_chain_state.sv
// sha256_chain_state: chaining-state sequencer for a double SHA-256 mining job.
//
// Holds the per-lane chaining value H0..H7 for LANES nonce lanes and steps
// through header block 1, header block 2 and (when DOUBLE) the block that
// hashes the first digest. The block-1 midstate is kept so later nonces of the
// same header can start directly at block 2.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   start_i          begin a job (accepted only when idle)
//   reuse_mid_i      with start_i: begin at block 2 from the stored midstate
//   mid_clr_i        invalidate the stored midstate
//   cmp_valid_i      compression result for the current block is on cmp_h_i
//   cmp_h_i          per-lane compression output, lane l at [256l+255:256l]
//   block_o          current block (0 idle, 1, 2, 3)
//   busy_o           job in progress
//   chain_h_o        per-lane chaining value for the current block
//   mid_valid_o      stored midstate is usable
//   inner_h_o        per-lane first digest (message for block 3)
//   digest_o         per-lane final digest
//   digest_valid_o   one-cycle pulse, digest_o is new
//   err_o            one-cycle pulse, cmp_valid_i seen while idle
// Word 0 of every 256-bit lane sits at the slice MSBs.
module sha256_chain_state #(
  parameter int unsigned LANES  = 1,
  parameter bit          DOUBLE = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   reuse_mid_i,
  input  logic                   mid_clr_i,
  input  logic                   cmp_valid_i,
  input  logic [LANES*256-1:0]   cmp_h_i,
  output logic [1:0]             block_o,
  output logic                   busy_o,
  output logic [LANES*256-1:0]   chain_h_o,
  output logic                   mid_valid_o,
  output logic [LANES*256-1:0]   inner_h_o,
  output logic [LANES*256-1:0]   digest_o,
  output logic                   digest_valid_o,
  output logic                   err_o
);

  localparam logic [255:0] Iv = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StB1   = 2'd1,
    StB2   = 2'd2,
    StB3   = 2'd3
  } state_e;

  // Eight independent 32-bit additions; carries never cross word boundaries.
  function automatic logic [255:0] add_words(input logic [255:0] a, input logic [255:0] b);
    logic [255:0] s;
    s = '0;
    for (int w = 0; w < 8; w++) begin
      s[32*w +: 32] = a[32*w +: 32] + b[32*w +: 32];
    end
    return s;
  endfunction

  state_e                 state_q, state_d;
  logic [LANES*256-1:0]   chain_q, chain_d;
  logic [255:0]           mid_q, mid_d;
  logic                   mid_valid_q, mid_valid_d;
  logic [LANES*256-1:0]   inner_q, inner_d;
  logic [LANES*256-1:0]   digest_q, digest_d;
  logic                   dv_q, dv_d;
  logic                   err_q, err_d;

  logic [255:0]           b1_sum;
  logic [LANES*256-1:0]   b2_sum;
  logic [LANES*256-1:0]   b3_sum;

  // Only lane 0 contributes to the shared midstate.
  assign b1_sum = add_words(cmp_h_i[255:0], Iv);

  always_comb begin
    b2_sum = '0;
    b3_sum = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      b2_sum[l*256 +: 256] = add_words(cmp_h_i[l*256 +: 256], chain_q[l*256 +: 256]);
      b3_sum[l*256 +: 256] = add_words(cmp_h_i[l*256 +: 256], Iv);
    end
  end

  always_comb begin
    state_d     = state_q;
    chain_d     = chain_q;
    mid_d       = mid_q;
    mid_valid_d = mid_valid_q;
    inner_d     = inner_q;
    digest_d    = digest_q;
    dv_d        = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        err_d = cmp_valid_i;
        if (start_i) begin
          // A same-cycle mid_clr already invalidates the midstate for this start.
          if (reuse_mid_i && mid_valid_q && !mid_clr_i) begin
            state_d = StB2;
            chain_d = {LANES{mid_q}};
          end else begin
            state_d = StB1;
            chain_d = {LANES{Iv}};
          end
        end
      end
      StB1: begin
        if (cmp_valid_i) begin
          mid_d       = b1_sum;
          mid_valid_d = 1'b1;
          chain_d     = {LANES{b1_sum}};
          state_d     = StB2;
        end
      end
      StB2: begin
        if (cmp_valid_i) begin
          chain_d = {LANES{Iv}};
          if (DOUBLE) begin
            inner_d = b2_sum;
            state_d = StB3;
          end else begin
            digest_d = b2_sum;
            dv_d     = 1'b1;
            state_d  = StIdle;
          end
        end
      end
      StB3: begin
        if (cmp_valid_i) begin
          digest_d = b3_sum;
          dv_d     = 1'b1;
          chain_d  = {LANES{Iv}};
          state_d  = StIdle;
        end
      end
    endcase

    // Clearing wins over a same-cycle capture; chain_d still carries the capture.
    if (mid_clr_i) begin
      mid_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      chain_q     <= {LANES{Iv}};
      mid_q       <= Iv;
      mid_valid_q <= 1'b0;
      inner_q     <= '0;
      digest_q    <= '0;
      dv_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      chain_q     <= chain_d;
      mid_q       <= mid_d;
      mid_valid_q <= mid_valid_d;
      inner_q     <= inner_d;
      digest_q    <= digest_d;
      dv_q        <= dv_d;
      err_q       <= err_d;
    end
  end

  assign block_o        = state_q;
  assign busy_o         = (state_q != StIdle);
  assign chain_h_o      = chain_q;
  assign mid_valid_o    = mid_valid_q;
  assign inner_h_o      = inner_q;
  assign digest_o       = digest_q;
  assign digest_valid_o = dv_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_sha256_chain_state.sv
// Bench for sha256_chain_state: a LANES=2 DOUBLE=1 instance checked every
// cycle against a word-array model, plus a LANES=1 DOUBLE=0 instance checked
// with directed literals.
module tb_sha256_chain_state;

  localparam int unsigned L = 2;
  localparam logic [255:0] IV_V = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                   32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Instance A (double SHA, two lanes)
  logic             start_a = 0, reuse_a = 0, mclr_a = 0, cmpv_a = 0;
  logic [L*256-1:0] cmph_a = '0;
  logic [1:0]       block_a;
  logic             busy_a, midv_a, dv_a, err_a;
  logic [L*256-1:0] chain_a, inner_a, digest_a;

  // Instance B (single SHA, one lane)
  logic         start_b = 0, cmpv_b = 0;
  logic [255:0] cmph_b = '0;
  logic [1:0]   block_b;
  logic         busy_b, midv_b, dv_b, err_b;
  logic [255:0] chain_b, inner_b, digest_b;

  sha256_chain_state #(.LANES(L), .DOUBLE(1'b1)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start_a), .reuse_mid_i(reuse_a), .mid_clr_i(mclr_a),
    .cmp_valid_i(cmpv_a), .cmp_h_i(cmph_a), .block_o(block_a), .busy_o(busy_a),
    .chain_h_o(chain_a), .mid_valid_o(midv_a), .inner_h_o(inner_a), .digest_o(digest_a),
    .digest_valid_o(dv_a), .err_o(err_a)
  );

  sha256_chain_state #(.LANES(1), .DOUBLE(1'b0)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .reuse_mid_i(1'b0), .mid_clr_i(1'b0),
    .cmp_valid_i(cmpv_b), .cmp_h_i(cmph_b), .block_o(block_b), .busy_o(busy_b),
    .chain_h_o(chain_b), .mid_valid_o(midv_b), .inner_h_o(inner_b), .digest_o(digest_b),
    .digest_valid_o(dv_b), .err_o(err_b)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ivw(input int w);
    logic [255:0] v;
    v = IV_V;
    return v[255-32*w -: 32];
  endfunction

  function automatic logic [31:0] cw(input logic [511:0] v, input int l, input int w);
    return v[l*256 + 255 - 32*w -: 32];
  endfunction

  // Model of instance A: block number plus per-lane word arrays.
  logic [1:0]  m_block;
  logic [31:0] m_chain [L][8];
  logic [31:0] m_inner [L][8];
  logic [31:0] m_digest[L][8];
  logic [31:0] m_mid   [8];
  logic        m_mid_valid, m_dv, m_err;

  always @(posedge clk) begin
    logic [31:0] t;
    if (rst) begin
      m_block     <= 2'd0;
      m_mid_valid <= 1'b0;
      m_dv        <= 1'b0;
      m_err       <= 1'b0;
      for (int w = 0; w < 8; w++) begin
        m_mid[w] <= ivw(w);
        for (int l = 0; l < L; l++) begin
          m_chain[l][w]  <= ivw(w);
          m_inner[l][w]  <= 32'h0;
          m_digest[l][w] <= 32'h0;
        end
      end
    end else begin
      m_dv  <= 1'b0;
      m_err <= 1'b0;
      case (m_block)
        2'd0: begin
          if (cmpv_a) m_err <= 1'b1;
          if (start_a) begin
            if (reuse_a && m_mid_valid && !mclr_a) begin
              m_block <= 2'd2;
              for (int l = 0; l < L; l++)
                for (int w = 0; w < 8; w++) m_chain[l][w] <= m_mid[w];
            end else begin
              m_block <= 2'd1;
              for (int l = 0; l < L; l++)
                for (int w = 0; w < 8; w++) m_chain[l][w] <= ivw(w);
            end
          end
        end
        2'd1: if (cmpv_a) begin
          for (int w = 0; w < 8; w++) begin
            t = cw(cmph_a, 0, w) + ivw(w);
            m_mid[w] <= t;
            for (int l = 0; l < L; l++) m_chain[l][w] <= t;
          end
          m_mid_valid <= 1'b1;
          m_block     <= 2'd2;
        end
        2'd2: if (cmpv_a) begin
          for (int l = 0; l < L; l++)
            for (int w = 0; w < 8; w++) begin
              m_inner[l][w] <= cw(cmph_a, l, w) + m_chain[l][w];
              m_chain[l][w] <= ivw(w);
            end
          m_block <= 2'd3;
        end
        default: if (cmpv_a) begin
          for (int l = 0; l < L; l++)
            for (int w = 0; w < 8; w++) begin
              m_digest[l][w] <= cw(cmph_a, l, w) + ivw(w);
              m_chain[l][w]  <= ivw(w);
            end
          m_dv    <= 1'b1;
          m_block <= 2'd0;
        end
      endcase
      if (mclr_a) m_mid_valid <= 1'b0;
    end
  end

  // Per-cycle comparison of instance A against the model.
  always @(negedge clk) begin
    logic [511:0] e_chain, e_inner, e_digest;
    if (cmp_en) begin
      for (int l = 0; l < L; l++)
        for (int w = 0; w < 8; w++) begin
          e_chain[l*256 + 255 - 32*w -: 32]  = m_chain[l][w];
          e_inner[l*256 + 255 - 32*w -: 32]  = m_inner[l][w];
          e_digest[l*256 + 255 - 32*w -: 32] = m_digest[l][w];
        end
      check("a_block", 512'(block_a), 512'(m_block));
      check("a_busy", 512'(busy_a), 512'(m_block != 2'd0));
      check("a_mid_valid", 512'(midv_a), 512'(m_mid_valid));
      check("a_chain_h", chain_a, e_chain);
      check("a_inner_h", inner_a, e_inner);
      check("a_digest", digest_a, e_digest);
      check("a_digest_valid", 512'(dv_a), 512'(m_dv));
      check("a_err", 512'(err_a), 512'(m_err));
      check("b_never_block3", 512'(block_b == 2'd3), 512'(0));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    step(); step();
    rst    = 1'b0;
    cmp_en = 1'b1;
    check("rst_block", 512'(block_a), 512'(0));
    check("rst_chain", chain_a, {2{IV_V}});
    check("rst_mid_valid", 512'(midv_a), 512'(0));

    // Plain double job with all-zero compression outputs.
    start_a = 1; step(); start_a = 0;
    check("j1_block1", 512'(block_a), 512'(1));
    cmpv_a = 1; cmph_a = '0;
    step(); check("j1_block2", 512'(block_a), 512'(2));
    check("j1_mid_is_iv", chain_a, {2{IV_V}});
    step(); check("j1_block3", 512'(block_a), 512'(3));
    check("j1_inner_iv", inner_a, {2{IV_V}});
    step(); cmpv_a = 0;
    check("j1_block0", 512'(block_a), 512'(0));
    check("j1_digest_iv", digest_a, {2{IV_V}});
    check("j1_dv_high", 512'(dv_a), 512'(1));
    step(); check("j1_dv_low", 512'(dv_a), 512'(0));

    // Per-word wrap without carry across words.
    start_a = 1; step(); start_a = 0;
    cmph_a = 512'h0; cmph_a[31:0] = 32'hffffffff; cmpv_a = 1;
    step(); cmpv_a = 0;
    check("w_mid_w7_l0", 512'(cw(chain_a, 0, 7)), 512'(32'h5be0cd18));
    check("w_mid_w7_l1", 512'(cw(chain_a, 1, 7)), 512'(32'h5be0cd18));
    check("w_mid_w6", 512'(cw(chain_a, 0, 6)), 512'(32'h1f83d9ab));
    cmph_a = '0; cmph_a[511:480] = 32'h2bf60000; cmph_a[223:192] = 32'hffffffff; cmpv_a = 1;
    step(); cmpv_a = 0;
    check("w_inner_l1w0", 512'(cw(inner_a, 1, 0)), 512'(32'h95ffe667));
    check("w_inner_l1w1", 512'(cw(inner_a, 1, 1)), 512'(32'hbb67ae85));
    check("w_inner_l0w1", 512'(cw(inner_a, 0, 1)), 512'(32'hbb67ae84));
    check("w_inner_l0w0", 512'(cw(inner_a, 0, 0)), 512'(32'h6a09e667));
    cmph_a = {16{32'h80000000}}; cmpv_a = 1;
    step(); cmpv_a = 0; cmph_a = '0;
    check("w_digest_w0", 512'(cw(digest_a, 1, 0)), 512'(32'hea09e667));
    check("w_digest_w1", 512'(cw(digest_a, 0, 1)), 512'(32'h3b67ae85));
    step();

    // Reuse the stored midstate; a start while busy is ignored.
    start_a = 1; reuse_a = 1; step(); start_a = 0; reuse_a = 0;
    check("r_block2", 512'(block_a), 512'(2));
    check("r_chain_w7", 512'(cw(chain_a, 1, 7)), 512'(32'h5be0cd18));
    step();
    cmph_a = {16{32'h01234567}}; cmpv_a = 1; step(); cmpv_a = 0;
    start_a = 1; step(); start_a = 0;
    check("r_busy_start_ignored", 512'(block_a), 512'(3));
    cmpv_a = 1; step(); cmpv_a = 0; cmph_a = '0;
    check("r_dv", 512'(dv_a), 512'(1));
    step();

    // mid_clr alone, then mid_clr racing the block-1 capture.
    mclr_a = 1; step(); mclr_a = 0;
    check("c_mid_cleared", 512'(midv_a), 512'(0));
    start_a = 1; reuse_a = 1; step(); start_a = 0; reuse_a = 0;
    check("c_block1", 512'(block_a), 512'(1));
    check("c_chain_iv", chain_a, {2{IV_V}});
    cmph_a[255:0] = {8{32'h11111111}}; cmpv_a = 1; mclr_a = 1;
    step(); cmpv_a = 0; mclr_a = 0; cmph_a = '0;
    check("c_midv_0", 512'(midv_a), 512'(0));
    check("c_block2", 512'(block_a), 512'(2));
    check("c_chain_l1w0", 512'(cw(chain_a, 1, 0)), 512'(32'h7b1af778));
    check("c_chain_l0w7", 512'(cw(chain_a, 0, 7)), 512'(32'h6cf1de2a));
    cmpv_a = 1; step(); step(); cmpv_a = 0;
    check("c_dv", 512'(dv_a), 512'(1));
    step();

    // Reset during block 2.
    start_a = 1; step(); start_a = 0;
    cmpv_a = 1; step(); cmpv_a = 0;
    check("x_block2", 512'(block_a), 512'(2));
    rst = 1; step(); rst = 0;
    check("x_block0", 512'(block_a), 512'(0));
    check("x_midv0", 512'(midv_a), 512'(0));
    check("x_chain_iv", chain_a, {2{IV_V}});
    check("x_no_dv", 512'(dv_a), 512'(0));
    step(); check("x_no_dv_late", 512'(dv_a), 512'(0));

    // cmp_valid while idle, then together with start.
    cmpv_a = 1; step(); cmpv_a = 0;
    check("e_err", 512'(err_a), 512'(1));
    check("e_idle", 512'(block_a), 512'(0));
    step(); check("e_err_low", 512'(err_a), 512'(0));
    start_a = 1; cmpv_a = 1; step(); start_a = 0; cmpv_a = 0;
    check("e_start_block1", 512'(block_a), 512'(1));
    check("e_start_err", 512'(err_a), 512'(1));
    cmpv_a = 1; step(); step(); step(); cmpv_a = 0;
    check("e_job_dv", 512'(dv_a), 512'(1));
    step();

    // Single SHA-256 instance.
    start_b = 1; step(); start_b = 0;
    check("s_block1", 512'(block_b), 512'(1));
    cmpv_b = 1; step();
    check("s_block2", 512'(block_b), 512'(2));
    step(); cmpv_b = 0;
    check("s_block0", 512'(block_b), 512'(0));
    check("s_digest_iv", 512'(digest_b), 512'(IV_V));
    check("s_dv", 512'(dv_b), 512'(1));
    step(); check("s_dv_low", 512'(dv_b), 512'(0));

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
